// File: rtl/indicator16_ram_if.sv
// Bus interface for indicator16_ram: address/data/control toward the RAM,
// registered read data back from it.
interface indicator16_ram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data;
  logic [DATA_W-1:0] datao;
  logic              WE;
  logic              RE;
  logic              SB;

  modport master (
    output Address, Data, WE, RE, SB,
    input  datao
  );

  modport slave (
    input  Address, Data, WE, RE, SB,
    output datao
  );
endinterface

// File: rtl/indicator16_ram.sv
// indicator16_ram: single-port synchronous RAM with registered read data
// (read-before-write on same-address collisions) plus an independent
// combinational hex-to-seven-segment decoder.
// Optional macro INDICATOR_ACTIVE_LOW_EN: inverts the segment outputs for
// common-anode displays. Default build drives active-high segments.
module indicator16_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  indicator16_ram_if.slave    bus,
  input  logic [3:0]          code,
  output logic [6:0]          segments
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is never cleared by reset; contents survive a reset pulse.
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] datao_r;
  logic [6:0]        seg_s;

  // Active-high pattern, bit6..bit0 = g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // Memory write: only when out of reset and the block is selected.
  always_ff @(posedge clk) begin
    if (reset && bus.SB && bus.WE) begin
      mem_r[bus.Address] <= bus.Data;
    end
  end

  // Read data register: cleared by reset, loaded on a qualified read, else held.
  // The nonblocking memory update gives the old word on a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      datao_r <= {DATA_W{1'b0}};
    end else if (bus.SB && bus.RE) begin
      datao_r <= mem_r[bus.Address];
    end else begin
      datao_r <= datao_r;
    end
  end

  assign bus.datao = datao_r;

  // Segment decode is purely combinational; polarity chosen at build time.
  always_comb begin
    seg_s = 7'h00;
`ifdef INDICATOR_ACTIVE_LOW_EN
    seg_s = ~hex_to_seg(code);
`else
    seg_s = hex_to_seg(code);
`endif
  end

  assign segments = seg_s;

endmodule

// File: tb/tb_indicator16_ram.sv
// Self-checking bench for indicator16_ram: stimulus pushes expected read data
// into a queue; a monitor pops and compares after every edge that produces
// new output (qualified read or reset).
module tb_indicator16_ram;

  logic       clk;
  logic       reset;
  logic [3:0] code;
  logic [6:0] segments;

  indicator16_ram_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  indicator16_ram #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .code     (code),
    .segments (segments)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: note at each edge whether datao is expected to change.
  always @(posedge clk) ev <= (!reset) || (bus.SB && bus.RE);

  // Monitor: compare datao against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (ev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL datao_unexpected: actual=%02h required=<no pending read>", bus.datao);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.datao !== e) begin
          failures++;
          $display("FAIL datao: actual=%02h required=%02h", bus.datao, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rst, input logic sb, input logic we, input logic re,
                       input logic [7:0] a, input logic [7:0] d);
    reset       = rst;
    bus.SB      = sb;
    bus.WE      = we;
    bus.RE      = re;
    bus.Address = a;
    bus.Data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    drive(1'b1, 1'b1, 1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%02h required=%02h", name, act, req);
    end
  endtask

  logic [6:0] seg_tab [16];

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    code = 4'h0;

    // Reset state: two reset edges, each must leave datao at 0.
    exp_q.push_back(8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_q.push_back(8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();

    // Write then read.
    wr(8'h10, 8'hA5);
    rd(8'h10, 8'hA5);

    // Deselected write must be ignored.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    rd(8'h10, 8'hA5);

    // Deselected read must not move datao.
    wr(8'h30, 8'h5A);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 8'h00);
    check_now("hold_deselect", bus.datao, 8'hA5);
    idle();
    check_now("hold_idle", bus.datao, 8'hA5);
    rd(8'h30, 8'h5A);

    // Read-before-write collision.
    wr(8'h20, 8'h11);
    exp_q.push_back(8'h11);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h22);
    rd(8'h20, 8'h22);

    // Reset clears datao, blocks a concurrent write, keeps memory.
    rd(8'h10, 8'hA5);
    exp_q.push_back(8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h77);
    idle();
    check_now("reset_hold", bus.datao, 8'h00);
    rd(8'h10, 8'hA5);

    // Boundary addresses.
    wr(8'h00, 8'h01);
    wr(8'hFF, 8'hFF);
    rd(8'h00, 8'h01);
    rd(8'hFF, 8'hFF);
    rd(8'h20, 8'h22);
    idle();
    idle();

    // Decoder sweep (combinational, while clock keeps running).
    for (int i = 0; i < 16; i++) begin
      logic [6:0] exp_seg;
      code = i[3:0];
      #1;
`ifdef INDICATOR_ACTIVE_LOW_EN
      exp_seg = ~seg_tab[i];
`else
      exp_seg = seg_tab[i];
`endif
      check_now($sformatf("segments_code%0h", i), {1'b0, segments}, {1'b0, exp_seg});
    end

    // Every expected read must have been consumed.
    check_now("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/indicator16_ram.md
INDICATOR16_RAM -- requirements
Module: indicator16_ram

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 clk  input  1  clock; all sequential logic SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 Address  input  ADDR_W  RAM word address.
REQ-006 Data  input  DATA_W  RAM write data.
REQ-007 datao  output  DATA_W  registered RAM read data.
REQ-008 WE  input  1  write enable, active-high.
REQ-009 RE  input  1  read enable, active-high.
REQ-010 SB  input  1  block select, active-high; WE and RE SHALL be ignored while SB=0.
REQ-011 code  input  4  hex digit to display.
REQ-012 segments  output  7  seven-segment pattern; bit0=a, bit1=b, ... bit6=g.

Function
REQ-013 Write: at a rising clk edge with reset=1, SB=1 and WE=1, mem[Address] SHALL take Data.
REQ-014 Read: at a rising clk edge with reset=1, SB=1 and RE=1, datao SHALL take mem[Address]; latency is 1 clock.
REQ-015 datao SHALL hold its previous value on any edge without a qualified read.
REQ-016 Simultaneous qualified read and write to the same address SHALL return the old contents on datao (read-before-write); the new value is visible on the next read.
REQ-017 The full address range 0..2**ADDR_W-1 SHALL be accessible; there is no out-of-range case.
REQ-018 The segment decoder SHALL be purely combinational and independent of clk, reset, SB, WE and RE.
REQ-019 Active-high segment patterns (hex, bits g..a) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 segments SHALL change within the same delta as code; there is no registered stage.

Reset
REQ-021 While reset=0 at a rising clk edge, datao SHALL become 0, and writes and reads SHALL be suppressed.
REQ-022 Reset SHALL NOT clear memory contents; locations SHALL retain their values across reset.
REQ-023 Memory contents before the first write are undefined; the bench SHALL NOT check them.
REQ-024 A reset asserted in the same cycle as WE=1 SHALL block that write.

Configuration
REQ-025 Macro INDICATOR_ACTIVE_LOW_EN: when defined, segments SHALL be the bitwise inverse of the REQ-019 patterns (common-anode drive).
REQ-026 When the macro is undefined, segments SHALL equal the REQ-019 active-high patterns.

Verification
REQ-027 Write then read: SB=1, WE=1, Address=0x10, Data=0xA5; next cycle RE=1 -> datao=0xA5 one clock later.
REQ-028 Deselect: SB=0, WE=1, Address=0x10, Data=0x00 -> subsequent read of 0x10 still returns 0xA5.
REQ-029 Read-before-write: mem[0x20]=0x11; same cycle RE=1, WE=1, Data=0x22 -> datao=0x11; the next read returns 0x22.
REQ-030 Reset: datao=0xA5, then drive reset=0 for one edge -> datao=0x00; a following read of 0x10 -> 0xA5.
REQ-031 Boundary addresses: write 0x01 to 0x00 and 0xFF to 0xFF -> reads return 0x01 and 0xFF with no aliasing.
REQ-032 Decoder sweep: code 0..F -> segments match REQ-019 (macro undefined), e.g. code=8 -> 0x7F; with the macro defined, code=8 -> 0x00.
